// File: rtl/sophon_ext_data_slv.sv
// sophon_ext_data_slv: wait-stated RAM responder for the core's external data port
module sophon_ext_data_slv #(
  parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter int          AMO_W     = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_i,
  input  logic             data_we_i,
  input  logic [31:0]      data_addr_i,
  input  logic [31:0]      data_wdata_i,
  input  logic [AMO_W-1:0] data_amo_i,
  input  logic [3:0]       data_strb_i,
  output logic             data_valid_o,
  output logic             data_error_o,
  output logic [31:0]      data_rdata_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAT = 4'(LATENCY);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic we_q, err_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0] strb_q;
  logic [31:0] off;
  logic idle, hit_err, c_we, c_err, enter_resp;
  logic [AW-1:0] c_idx;
  logic [31:0] c_wdata;
  logic [3:0] c_strb;
  logic [31:0] mem [DEPTH];
  // window decode, and the live-or-latched request seen by the RESP-entry edge
  always_comb begin
    off = data_addr_i - BASE_ADDR;
    hit_err = (off >= SPAN) || (data_amo_i != '0);
    idle = state == IDLE;
    c_we = idle ? data_we_i : we_q;
    c_err = idle ? hit_err : err_q;
    c_idx = idle ? off[AW+1:2] : idx_q;
    c_wdata = idle ? data_wdata_i : wdata_q;
    c_strb = idle ? data_strb_i : strb_q;
    nxt = idle ? (data_req_i ? (LAT == 4'd0 ? RESP : WAIT) : IDLE)
               : (state == WAIT ? (cnt == 4'd1 ? RESP : WAIT) : IDLE);
    enter_resp = nxt == RESP;
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= nxt;
  // request latch, wait counter and registered response
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= '0;
      strb_q <= '0;
      data_valid_o <= 1'b0;
      data_error_o <= 1'b0;
      data_rdata_o <= '0;
    end else begin
      if (idle && data_req_i) begin
        cnt <= LAT;
        we_q <= data_we_i;
        err_q <= hit_err;
        idx_q <= off[AW+1:2];
        wdata_q <= data_wdata_i;
        strb_q <= data_strb_i;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      data_valid_o <= enter_resp;
      data_error_o <= enter_resp && c_err;
      data_rdata_o <= (enter_resp && !c_err && !c_we) ? mem[c_idx] : '0;
    end
  // RAM write only on the RESP-entry edge so an aborted request never commits
  always_ff @(posedge clk_i)
    if (rst_ni && enter_resp && c_we && !c_err)
      for (int b = 0; b < 4; b++)
        if (c_strb[b]) mem[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
endmodule

// File: tb/tb_sophon_ext_data_slv.sv
// tb_sophon_ext_data_slv: directed self-checking bench for sophon_ext_data_slv
module tb_sophon_ext_data_slv;
  logic clk, rst_n, we;
  logic [31:0] addr, wdata;
  logic [5:0] amo;
  logic [3:0] strb;
  logic req2, req0, req1, req15;
  logic v2, v0, v1, v15, e2, e0, e1, e15;
  logic [31:0] rd2, rd0, rd1, rd15;
  int errors = 0;
  int checks = 0;

  sophon_ext_data_slv #(.LATENCY(2)) u2 (.clk_i(clk), .rst_ni(rst_n), .data_req_i(req2), .data_we_i(we),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_amo_i(amo), .data_strb_i(strb),
    .data_valid_o(v2), .data_error_o(e2), .data_rdata_o(rd2));
  sophon_ext_data_slv #(.LATENCY(0)) u0 (.clk_i(clk), .rst_ni(rst_n), .data_req_i(req0), .data_we_i(we),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_amo_i(amo), .data_strb_i(strb),
    .data_valid_o(v0), .data_error_o(e0), .data_rdata_o(rd0));
  sophon_ext_data_slv #(.LATENCY(1)) u1 (.clk_i(clk), .rst_ni(rst_n), .data_req_i(req1), .data_we_i(we),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_amo_i(amo), .data_strb_i(strb),
    .data_valid_o(v1), .data_error_o(e1), .data_rdata_o(rd1));
  sophon_ext_data_slv #(.LATENCY(15)) u15 (.clk_i(clk), .rst_ni(rst_n), .data_req_i(req15), .data_we_i(we),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_amo_i(amo), .data_strb_i(strb),
    .data_valid_o(v15), .data_error_o(e15), .data_rdata_o(rd15));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [5:0] m, output int n, output logic e, output logic [31:0] r);
    we = w; addr = a; wdata = d; strb = s; amo = m; req2 = 1'b1;
    n = -1; e = 1'b0; r = '0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (v2) begin
        n = k; e = e2; r = rd2;
        break;
      end
    end
    req2 = 1'b0; amo = '0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0; req2 = 1'b1; we = 1'b1; addr = 32'h9000_0040; wdata = '0; strb = 4'h0; amo = '0;
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({v2, e2, rd2} !== 34'b0) begin
        errors++; $display("FAIL reset_outputs: got v=%b e=%b rd=%h, want all 0", v2, e2, rd2);
      end
    end
    rst_n = 1'b1; n = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); @(negedge clk);
      if (v2) begin n = k; break; end
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL reset_first_valid: got %0d edges, want 3", n); end
    req2 = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (v2 !== 1'b0) begin errors++; $display("FAIL reset_pulse_width: valid=%b, want 0", v2); end
  endtask

  task automatic test_write_read();
    int n; logic e; logic [31:0] r;
    xact(1'b1, 32'h9000_0010, 32'hDEADBEEF, 4'hF, 6'h0, n, e, r);
    checks++;
    if (n !== 3 || e !== 1'b0 || r !== 32'h0) begin
      errors++; $display("FAIL write_resp: lat=%0d e=%b rd=%h, want 3 0 00000000", n, e, r);
    end
    xact(1'b0, 32'h9000_0010, 32'h0, 4'h0, 6'h0, n, e, r);
    checks++;
    if (n !== 3 || e !== 1'b0 || r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_back: lat=%0d e=%b rd=%h, want 3 0 deadbeef", n, e, r);
    end
    checks++;
    if ({v2, e2, rd2} !== 34'b0) begin
      errors++; $display("FAIL idle_outputs: v=%b e=%b rd=%h, want all 0", v2, e2, rd2);
    end
  endtask

  task automatic test_strobes();
    int n; logic e; logic [31:0] r;
    xact(1'b1, 32'h9000_0010, 32'h1122_3344, 4'b0101, 6'h0, n, e, r);
    xact(1'b0, 32'h9000_0010, 32'h0, 4'hF, 6'h0, n, e, r);
    checks++;
    if (r !== 32'hDE22BE44 || e !== 1'b0) begin
      errors++; $display("FAIL strobe_merge: rd=%h e=%b, want de22be44 0", r, e);
    end
    xact(1'b1, 32'h9000_0010, 32'hFFFF_FFFF, 4'b0000, 6'h0, n, e, r);
    checks++;
    if (n !== 3 || e !== 1'b0) begin errors++; $display("FAIL strb0_resp: lat=%0d e=%b, want 3 0", n, e); end
    xact(1'b0, 32'h9000_0010, 32'h0, 4'h0, 6'h0, n, e, r);
    checks++;
    if (r !== 32'hDE22BE44) begin errors++; $display("FAIL strb0_nochange: rd=%h, want de22be44", r); end
  endtask

  task automatic test_errors();
    int n; logic e; logic [31:0] r;
    xact(1'b0, 32'h8FFF_FFFC, 32'h0, 4'hF, 6'h0, n, e, r);
    checks++;
    if (n !== 3 || e !== 1'b1 || r !== 32'h0) begin
      errors++; $display("FAIL below_window: lat=%0d e=%b rd=%h, want 3 1 00000000", n, e, r);
    end
    xact(1'b1, 32'h9000_0FFC, 32'h5A5A_1234, 4'hF, 6'h0, n, e, r);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL last_word_write: e=%b, want 0", e); end
    xact(1'b1, 32'h9000_1000, 32'hFFFF_FFFF, 4'hF, 6'h0, n, e, r);
    checks++;
    if (e !== 1'b1 || r !== 32'h0) begin
      errors++; $display("FAIL above_window: e=%b rd=%h, want 1 00000000", e, r);
    end
    xact(1'b0, 32'h9000_0FFC, 32'h0, 4'hF, 6'h0, n, e, r);
    checks++;
    if (r !== 32'h5A5A_1234 || e !== 1'b0) begin
      errors++; $display("FAIL last_word_kept: rd=%h e=%b, want 5a5a1234 0", r, e);
    end
    xact(1'b1, 32'h9000_0010, 32'h0, 4'hF, 6'h01, n, e, r);
    checks++;
    if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL amo_error: e=%b rd=%h, want 1 00000000", e, r); end
    xact(1'b0, 32'h9000_0010, 32'h0, 4'hF, 6'h0, n, e, r);
    checks++;
    if (r !== 32'hDE22BE44) begin errors++; $display("FAIL amo_nochange: rd=%h, want de22be44", r); end
  endtask

  task automatic test_back_to_back();
    int lat_v[3] = '{0, 1, 15};
    int first[3] = '{-1, -1, -1};
    int last[3] = '{0, 0, 0};
    int cnt[3] = '{0, 0, 0};
    int bad[3] = '{0, 0, 0};
    logic vv[3];
    we = 1'b1; addr = 32'h9000_0000; wdata = 32'h0BAD_F00D; strb = 4'hF; amo = '0;
    req0 = 1'b1; req1 = 1'b1; req15 = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); @(negedge clk);
      vv[0] = v0; vv[1] = v1; vv[2] = v15;
      for (int j = 0; j < 3; j++)
        if (vv[j]) begin
          if (cnt[j] == 0) first[j] = k;
          else if (k - last[j] != lat_v[j] + 2) bad[j]++;
          last[j] = k;
          cnt[j]++;
        end
    end
    req0 = 1'b0; req1 = 1'b0; req15 = 1'b0;
    repeat (20) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (first[j] != lat_v[j] + 1) begin
        errors++; $display("FAIL b2b_first_lat%0d: got %0d, want %0d", lat_v[j], first[j], lat_v[j] + 1);
      end
      checks++;
      if (bad[j] != 0) begin errors++; $display("FAIL b2b_gap_lat%0d: %0d bad gaps, want 0", lat_v[j], bad[j]); end
      checks++;
      if (cnt[j] != (80 - (lat_v[j] + 1)) / (lat_v[j] + 2) + 1) begin
        errors++; $display("FAIL b2b_count_lat%0d: got %0d, want %0d", lat_v[j], cnt[j],
                           (80 - (lat_v[j] + 1)) / (lat_v[j] + 2) + 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, pulses; logic e; logic [31:0] r;
    xact(1'b1, 32'h9000_0020, 32'h0, 4'hF, 6'h0, n, e, r);
    we = 1'b1; addr = 32'h9000_0020; wdata = 32'hCAFE_F00D; strb = 4'hF; amo = '0; req2 = 1'b1;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0; req2 = 1'b0;
    #1;
    checks++;
    if ({v2, e2, rd2} !== 34'b0) begin
      errors++; $display("FAIL midreset_outputs: v=%b e=%b rd=%h, want all 0", v2, e2, rd2);
    end
    pulses = 0;
    repeat (3) begin @(negedge clk); if (v2) pulses++; end
    rst_n = 1'b1;
    repeat (6) begin @(negedge clk); if (v2) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL midreset_no_valid: %0d pulses, want 0", pulses); end
    xact(1'b0, 32'h9000_0020, 32'h0, 4'hF, 6'h0, n, e, r);
    checks++;
    if (n !== 3 || r !== 32'h0) begin
      errors++; $display("FAIL midreset_dropped: lat=%0d rd=%h, want 3 00000000", n, r);
    end
  endtask

  task automatic test_req_drop();
    int n, seen; logic e; logic [31:0] r;
    we = 1'b1; addr = 32'h9000_0030; wdata = 32'h1357_9BDF; strb = 4'hF; amo = '0; req2 = 1'b1;
    @(posedge clk); @(negedge clk);
    req2 = 1'b0; seen = 0;
    repeat (10) begin @(posedge clk); @(negedge clk); if (v2) seen++; end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL drop_completes: %0d pulses, want 1", seen); end
    xact(1'b0, 32'h9000_0030, 32'h0, 4'hF, 6'h0, n, e, r);
    checks++;
    if (r !== 32'h1357_9BDF) begin errors++; $display("FAIL drop_committed: rd=%h, want 13579bdf", r); end
  endtask

  initial begin
    rst_n = 1'b0; req2 = 1'b0; req0 = 1'b0; req1 = 1'b0; req15 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; amo = '0; strb = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_strobes();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_req_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
